// File: rtl/vec_lane_sequencer.sv
// rtl/vec_lane_sequencer.sv - sequences one 16-bit lane ALU across the lanes of a vector op
module vec_lane_sequencer #(
   parameter int LANES         = 4,
   parameter int LANE_WIDTH    = 16,
   parameter int VREG_ID_WIDTH = 6
) (
   input  logic                          I_CLOCK,
   input  logic                          I_RESET,
   input  logic                          I_Start,
   input  logic [1:0]                    I_Op,
   input  logic [LANES*LANE_WIDTH-1:0]   I_VecSrc1Value,
   input  logic [LANES*LANE_WIDTH-1:0]   I_VecSrc2Value,
   input  logic [LANE_WIDTH-1:0]         I_Imm,
   input  logic [LANE_WIDTH-1:0]         I_Src1Value,
   input  logic [$clog2(LANES)-1:0]      I_Idx,
   input  logic [VREG_ID_WIDTH-1:0]      I_DestVRegIdx,
   input  logic                          I_GPUStallSignal,
   output logic                          O_Busy,
   output logic [$clog2(LANES)-1:0]      O_LaneIdx,
   output logic [LANES*LANE_WIDTH-1:0]   O_VecDestValue,
   output logic [VREG_ID_WIDTH-1:0]      O_DestVRegIdx,
   output logic                          O_VRegWEn,
   output logic                          O_Done
);

   localparam int LW = $clog2(LANES);
   localparam int VW = LANES * LANE_WIDTH;

   localparam logic [1:0] OP_VADD     = 2'b00;
   localparam logic [1:0] OP_VMOV     = 2'b01;
   localparam logic [1:0] OP_VMOVI    = 2'b10;
   localparam logic [1:0] OP_VCOMPMOV = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t state, state_next;

   logic [1:0]               op_q;
   logic [VW-1:0]            src1_q;
   logic [VW-1:0]            src2_q;
   logic [LANE_WIDTH-1:0]    imm_q;
   logic [LANE_WIDTH-1:0]    scalar_q;
   logic [LW-1:0]            idx_q;
   logic [VREG_ID_WIDTH-1:0] dest_q;
   logic [LW-1:0]            lane_q;
   logic [VW-1:0]            result_q;
   logic                     busy_q;

   logic                     accept;
   logic                     lane_step;
   logic                     last_lane;
   logic [LANE_WIDTH-1:0]    lane_src1;
   logic [LANE_WIDTH-1:0]    lane_src2;
   logic [LANE_WIDTH-1:0]    lane_val;

   always_ff @(posedge I_CLOCK) begin
      if (I_RESET) state <= S_IDLE;
      else         state <= state_next;
   end

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      lane_step  = 1'b0;
      O_VRegWEn  = 1'b0;
      O_Done     = 1'b0;
      case (state)
         S_IDLE: begin
            if (I_Start && !I_GPUStallSignal) begin
               accept     = 1'b1;
               state_next = S_RUN;
            end
         end
         S_RUN: begin
            if (!I_GPUStallSignal) begin
               lane_step = 1'b1;
               if (last_lane) state_next = S_DONE;
            end
         end
         S_DONE: begin
            O_VRegWEn = 1'b1;
            O_Done    = 1'b1;
            if (!I_GPUStallSignal) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   assign last_lane = (lane_q == LW'(LANES - 1));
   assign lane_src1 = src1_q[lane_q*LANE_WIDTH +: LANE_WIDTH];
   assign lane_src2 = src2_q[lane_q*LANE_WIDTH +: LANE_WIDTH];

   // Lanes are independent: VADD wraps per lane with no carry into the neighbour.
   always_comb begin
      lane_val = lane_src1;
      case (op_q)
         OP_VADD:     lane_val = lane_src1 + lane_src2;
         OP_VMOV:     lane_val = lane_src1;
         OP_VMOVI:    lane_val = imm_q;
         OP_VCOMPMOV: lane_val = (lane_q == idx_q) ? scalar_q : lane_src1;
         default:     lane_val = lane_src1;
      endcase
   end

   always_ff @(posedge I_CLOCK) begin
      if (I_RESET) begin
         op_q     <= '0;
         src1_q   <= '0;
         src2_q   <= '0;
         imm_q    <= '0;
         scalar_q <= '0;
         idx_q    <= '0;
         dest_q   <= '0;
         lane_q   <= '0;
         result_q <= '0;
         busy_q   <= 1'b0;
      end else begin
         busy_q <= (state_next != S_IDLE);
         if (accept) begin
            op_q     <= I_Op;
            src1_q   <= I_VecSrc1Value;
            src2_q   <= I_VecSrc2Value;
            imm_q    <= I_Imm;
            scalar_q <= I_Src1Value;
            idx_q    <= I_Idx;
            dest_q   <= I_DestVRegIdx;
            lane_q   <= '0;
            result_q <= '0;
         end else if (lane_step) begin
            result_q[lane_q*LANE_WIDTH +: LANE_WIDTH] <= lane_val;
            if (!last_lane) lane_q <= lane_q + LW'(1);
         end
      end
   end

   assign O_Busy         = busy_q;
   assign O_LaneIdx      = lane_q;
   assign O_VecDestValue = result_q;
   assign O_DestVRegIdx  = dest_q;

endmodule

// File: tb/tb_vec_lane_sequencer.sv
// tb/tb_vec_lane_sequencer.sv - directed-vector bench for vec_lane_sequencer
module tb_vec_lane_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [63:0] vsrc1, vsrc2;
   logic [15:0] imm, scalar;
   logic [1:0]  idx;
   logic [5:0]  dest;
   logic        stall;
   logic        busy;
   logic [1:0]  lane;
   logic [63:0] vdest;
   logic [5:0]  dest_out;
   logic        wen, done;

   int n_vec = 0;
   int n_err = 0;

   vec_lane_sequencer #(.LANES(4), .LANE_WIDTH(16), .VREG_ID_WIDTH(6)) dut (
      .I_CLOCK         (clk),
      .I_RESET         (rst),
      .I_Start         (start),
      .I_Op            (op),
      .I_VecSrc1Value  (vsrc1),
      .I_VecSrc2Value  (vsrc2),
      .I_Imm           (imm),
      .I_Src1Value     (scalar),
      .I_Idx           (idx),
      .I_DestVRegIdx   (dest),
      .I_GPUStallSignal(stall),
      .O_Busy          (busy),
      .O_LaneIdx       (lane),
      .O_VecDestValue  (vdest),
      .O_DestVRegIdx   (dest_out),
      .O_VRegWEn       (wen),
      .O_Done          (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_op(input logic [1:0] o, input logic [63:0] s1, input logic [63:0] s2,
                         input logic [15:0] im, input logic [15:0] sc, input logic [1:0] ix,
                         input logic [5:0] d);
      op = o; vsrc1 = s1; vsrc2 = s2; imm = im; scalar = sc; idx = ix; dest = d;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; stall = 1'b0;
      set_op(2'b00, 64'h0, 64'h0, 16'h0, 16'h0, 2'd0, 6'd0);
      tick(2);
      chk("rst_busy",  64'(busy),     64'd0);
      chk("rst_lane",  64'(lane),     64'd0);
      chk("rst_value", vdest,         64'd0);
      chk("rst_dest",  64'(dest_out), 64'd0);
      chk("rst_wen",   64'(wen),      64'd0);
      chk("rst_done",  64'(done),     64'd0);
      rst = 1'b0;
      tick();

      // VADD with lane-0 wrap, checking exact latency
      set_op(2'b00, 64'h0004_0003_0002_0001, 64'h0010_0020_0030_FFFF, 16'h0, 16'h0, 2'd0, 6'd5);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("vadd_busy_T",  64'(busy), 64'd1);
      chk("vadd_lane_T",  64'(lane), 64'd0);
      tick(3);
      chk("vadd_wen_T3",  64'(wen),  64'd0);
      chk("vadd_lane_T3", 64'(lane), 64'd3);
      tick();
      chk("vadd_wen_T4",  64'(wen),      64'd1);
      chk("vadd_done_T4", 64'(done),     64'd1);
      chk("vadd_value",   vdest,         64'h0014_0023_0032_0000);
      chk("vadd_dest",    64'(dest_out), 64'd5);
      tick();
      chk("vadd_wen_T5",  64'(wen),  64'd0);
      chk("vadd_busy_T5", 64'(busy), 64'd0);
      chk("vadd_hold",    vdest,     64'h0014_0023_0032_0000);

      // same VADD with a 3-cycle stall at lane 1
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("stall_clear", vdest, 64'd0);
      tick();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_lane", 64'(lane), 64'd1);
      end
      stall = 1'b0;
      tick(2);
      chk("stall_wen_T6", 64'(wen), 64'd0);
      tick();
      chk("stall_wen_T7", 64'(wen), 64'd1);
      chk("stall_value",  vdest,    64'h0014_0023_0032_0000);
      tick();

      // VMOVI with a 2-cycle stall held during DONE
      set_op(2'b10, 64'hDEAD_BEEF_0000_1234, 64'h0, 16'h00A5, 16'h0, 2'd0, 6'd9);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick(4);
      chk("vmovi_wen0", 64'(wen), 64'd1);
      stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("vmovi_wen_held", 64'(wen),      64'd1);
         chk("vmovi_value",    vdest,         64'h00A5_00A5_00A5_00A5);
         chk("vmovi_dest",     64'(dest_out), 64'd9);
      end
      stall = 1'b0;
      tick();
      chk("vmovi_wen_end",  64'(wen),  64'd0);
      chk("vmovi_busy_end", 64'(busy), 64'd0);

      // reset while computing lane 2 discards the op
      set_op(2'b01, 64'h7777_6666_5555_4444, 64'h0, 16'h0, 16'h0, 2'd0, 6'd33);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick(2);
      chk("mid_lane", 64'(lane), 64'd2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mrst_busy",  64'(busy),     64'd0);
      chk("mrst_lane",  64'(lane),     64'd0);
      chk("mrst_value", vdest,         64'd0);
      chk("mrst_dest",  64'(dest_out), 64'd0);
      chk("mrst_wen",   64'(wen),      64'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("mrst_no_wen", 64'(wen), 64'd0);
      end

      // VCOMPMOV after reset completes normally
      set_op(2'b11, 64'h1111_2222_3333_4444, 64'h0, 16'h0, 16'hBEEF, 2'd2, 6'd12);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick(4);
      chk("vcmp_wen",   64'(wen),      64'd1);
      chk("vcmp_value", vdest,         64'h1111_BEEF_3333_4444);
      chk("vcmp_dest",  64'(dest_out), 64'd12);
      tick();

      // Start held continuously across two ops
      set_op(2'b01, 64'hAAAA_BBBB_CCCC_DDDD, 64'h0, 16'h0, 16'h0, 2'd0, 6'd1);
      start = 1'b1;
      tick();
      set_op(2'b00, 64'h0001_0001_0001_0001, 64'hFFFF_0001_0002_0003, 16'h0, 16'h0, 2'd0, 6'd2);
      tick(3);
      chk("b2b_busy_T4", 64'(busy), 64'd1);
      tick();
      chk("b2b_wen1",   64'(wen),      64'd1);
      chk("b2b_value1", vdest,         64'hAAAA_BBBB_CCCC_DDDD);
      chk("b2b_dest1",  64'(dest_out), 64'd1);
      tick();
      chk("b2b_busy_T5", 64'(busy), 64'd0);
      tick();
      chk("b2b_busy_T6", 64'(busy), 64'd1);
      start = 1'b0;
      tick(4);
      chk("b2b_wen2",   64'(wen),      64'd1);
      chk("b2b_value2", vdest,         64'h0000_0002_0003_0004);
      chk("b2b_dest2",  64'(dest_out), 64'd2);
      tick();
      chk("b2b_idle", 64'(busy), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
